delta_emitter: RTL and testbench
================================

Name: delta_emitter

Overview:
- Streaming delta encoder: the transmit end of the running-sum path.
- Accepts absolute samples and emits the modular difference from the previous accepted sample.
- A downstream accumulator summing the emitted deltas reconstructs each sample mod 2^WIDTH_P.
- Valid/ready handshakes on both sides; 2-entry output skid buffer for full throughput.

Parameters:
- WIDTH_P, 8, width of samples and deltas in bits.

Ports:
- clk_i  input  1  clock; all flops rise-edge.
- rst_ni  input  1  asynchronous active-low reset.
- sample_i  input  WIDTH_P  absolute sample value.
- sample_valid_i  input  1  sample_i is valid this cycle.
- sample_ready_o  output  1  block can accept a sample this cycle.
- resync_i  input  1  pulse: next delta is computed against zero.
- delta_o  output  WIDTH_P  head-of-buffer delta, unsigned mod 2^WIDTH_P.
- first_o  output  1  delta_o was computed against a zero reference (after reset or resync).
- delta_valid_o  output  1  delta_o/first_o valid.
- delta_ready_i  input  1  consumer takes the head entry this cycle.

Behaviour:
- Interface timing: one clock, clk_i. rst_ni is asynchronous assert, active-low. Release is synchronous to clk_i via the external reset synchronizer.
- Reset values:
  - ref_q=0, first_pend_q=1, buffer EMPTY.
  - delta_o=0, first_o=0, delta_valid_o=0, sample_ready_o=1 (after release).
- Accept = sample_valid_i & sample_ready_o.
- On accept:
  - delta = (sample_i - ref_eff) truncated to WIDTH_P bits; wrap-around is intended, e.g. 0x02-0xFE=0x04.
  - ref_eff = 0 if resync_i is high this cycle, else ref_q.
  - ref_q <= sample_i.
  - Entry first flag = first_pend_q | resync_i.
- first_pend_q:
  - Cleared when an entry is enqueued.
  - Set when resync_i is high without an accept.
  - Also set at reset.
- resync_i without accept: ref_q <= 0 at that edge.
- Latency: a sample accepted at edge n appears on delta_o with delta_valid_o=1 after edge n (registered output, 1 cycle).
- Output buffer FSM, states EMPTY, ONE, TWO; push = enqueue, pop = delta_valid_o & delta_ready_i.
  - EMPTY: push -> ONE.
  - ONE:
    - push & pop -> ONE; the new entry becomes head the next cycle.
    - push only -> TWO.
    - pop only -> EMPTY.
  - TWO: no push possible; pop -> ONE, and the second entry moves to head.
- sample_ready_o = (state != TWO); it is a registered-state decode with no combinational path from delta_ready_i.
- delta_valid_o = (state != EMPTY).
- delta_o/first_o are stable while delta_valid_o=1 and delta_ready_i=0.
- Reset mid-stream: all buffered deltas are discarded, the reference returns to 0, and the first delta after reset has first_o=1.

Optional Feature:
- Macro: DELTA_EMITTER_ZERO_SKIP_EN.
- Defined:
  - An accept whose delta is 0 is consumed and not enqueued.
  - ref_q still updates.
  - first_pend_q is not cleared, so the flag rides on the next nonzero delta.
  - The next emitted delta is still relative to the skipped sample, so reconstruction is exact.
- Undefined: every accept enqueues exactly one entry, including zero deltas.

Decomposition:
- Package delta_emitter_pkg:
  - Default width constant DELTA_WIDTH_DEF=8.
  - Buffer state encoding constants: BUF_EMPTY=2'd0, BUF_ONE=2'd1, BUF_TWO=2'd2.
- Sub-module delta_skid_buf:
  - 2-entry valid/ready FIFO of {first, delta}, width WIDTH_P+1.
  - Owns the EMPTY/ONE/TWO FSM.
- Top level holds the subtractor, ref_q, first_pend_q and the zero-skip gate.

Test Plan:
- Reset then samples 0x10, 0x15, 0x13, consumer always ready -> deltas 0x10 (first_o=1), 0x05, 0xFE (first_o=0), each one cycle after its accept.
- Sample 0xFE then 0x02 -> second delta 0x04 (wrap). Summing all emitted deltas mod 256 equals the last sample.
- delta_ready_i=0, feed 3 samples back-to-back -> two accepted and sample_ready_o=0 from the next cycle; raise delta_ready_i -> FIFO order preserved; the third sample is accepted once the buffer is back to ONE; no loss or duplication.
- Samples 0x20 then 0x30 with resync_i high on the 0x30 accept -> delta 0x30, first_o=1. With resync_i high in an idle cycle before 0x40 -> delta 0x40, first_o=1.
- ZERO_SKIP_EN defined, samples 0x07, 0x07, 0x09 -> only 0x07 (first_o=1) and 0x02 emitted. After a resync, sample 0x00 then 0x05 -> single delta 0x05 with first_o=1.
- Assert rst_ni mid-stream with 2 entries buffered -> delta_valid_o=0 immediately (async). After release, sample 0x33 -> delta 0x33, first_o=1.

Source files
------------

// File: rtl/delta_emitter_pkg.sv
// Shared constants and the output-buffer state type for the delta_emitter block.
package delta_emitter_pkg;

  localparam int DELTA_WIDTH_DEF = 8;

  localparam logic [1:0] BUF_EMPTY = 2'd0;
  localparam logic [1:0] BUF_ONE   = 2'd1;
  localparam logic [1:0] BUF_TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = BUF_EMPTY,
    ST_ONE   = BUF_ONE,
    ST_TWO   = BUF_TWO
  } buf_state_e;

endpackage

// File: rtl/delta_skid_buf.sv
// Two-entry valid/ready skid FIFO; the head entry is always held in a register
// so the output never depends combinationally on the consumer's ready.
module delta_skid_buf
  import delta_emitter_pkg::*;
#(
  parameter int DATA_W = DELTA_WIDTH_DEF + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  buf_state_e        state;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic              push;
  logic              pop;

  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = head;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // When both slots are full the second entry is promoted to head on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            head  <= in_data;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head <= in_data;
          end else if (push) begin
            tail  <= in_data;
            state <= ST_TWO;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head  <= tail;
            state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/delta_emitter.sv
// Streaming delta encoder: emits (sample - previous sample) mod 2^WIDTH_P.
// Define DELTA_EMITTER_ZERO_SKIP_EN to drop zero deltas instead of enqueueing them.
module delta_emitter
  import delta_emitter_pkg::*;
#(
  parameter int WIDTH_P = DELTA_WIDTH_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [WIDTH_P-1:0] sample_i,
  input  logic               sample_valid_i,
  output logic               sample_ready_o,
  input  logic               resync_i,
  output logic [WIDTH_P-1:0] delta_o,
  output logic               first_o,
  output logic               delta_valid_o,
  input  logic               delta_ready_i
);

  logic [WIDTH_P-1:0] ref_q;
  logic [WIDTH_P-1:0] ref_eff;
  logic [WIDTH_P-1:0] delta;
  logic               first_pend_q;
  logic               accept;
  logic               push;
  logic               entry_first;
  logic [WIDTH_P:0]   head;

  assign accept      = sample_valid_i & sample_ready_o;
  assign ref_eff     = resync_i ? '0 : ref_q;
  assign delta       = sample_i - ref_eff;
  assign entry_first = first_pend_q | resync_i;

`ifdef DELTA_EMITTER_ZERO_SKIP_EN
  // A skipped sample still becomes the reference, so the next delta stays exact.
  assign push = accept & (delta != '0);
`else
  assign push = accept;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_q        <= '0;
      first_pend_q <= 1'b1;
    end else begin
      if (accept) begin
        ref_q <= sample_i;
      end else if (resync_i) begin
        ref_q <= '0;
      end
      // The first flag survives a skipped accept so it rides on the next real entry.
      if (push) begin
        first_pend_q <= 1'b0;
      end else if (resync_i) begin
        first_pend_q <= 1'b1;
      end
    end
  end

  delta_skid_buf #(
    .DATA_W(WIDTH_P + 1)
  ) u_skid (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .in_data  ({entry_first, delta}),
    .in_valid (push),
    .in_ready (sample_ready_o),
    .out_data (head),
    .out_valid(delta_valid_o),
    .out_ready(delta_ready_i)
  );

  assign delta_o = head[WIDTH_P-1:0];
  assign first_o = head[WIDTH_P];

endmodule

// File: tb/tb_delta_emitter.sv
// Self-checking bench for delta_emitter: directed scenarios plus random traffic
// against a queue-based reference model and a downstream reconstruction check.
module tb_delta_emitter;

  typedef struct packed {
    logic       first;
    logic [7:0] delta;
  } entry_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] sample_i = '0;
  logic       sample_valid_i = 1'b0;
  logic       sample_ready_o;
  logic       resync_i = 1'b0;
  logic [7:0] delta_o;
  logic       first_o;
  logic       delta_valid_o;
  logic       delta_ready_i = 1'b0;

  int compared = 0;
  int mismatched = 0;

  entry_t     model_q[$];
  logic [7:0] sample_q[$];
  logic [7:0] model_ref;
  logic       model_first;
  logic [7:0] recon;

  delta_emitter #(.WIDTH_P(8)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sample_i      (sample_i),
    .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o),
    .resync_i      (resync_i),
    .delta_o       (delta_o),
    .first_o       (first_o),
    .delta_valid_o (delta_valid_o),
    .delta_ready_i (delta_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    sample_q.delete();
    model_ref   = 8'h00;
    model_first = 1'b1;
    recon       = 8'h00;
  endtask

  // One clock cycle: drive at negedge, check against the model, then advance the model at posedge.
  task automatic applyStimulus(input logic v, input logic [7:0] s, input logic rs, input logic rd);
    logic       exp_ready;
    logic       exp_valid;
    logic       acc;
    logic       pop;
    logic       skip;
    logic [7:0] d;
    logic [7:0] obs_d;
    logic       obs_f;
    entry_t     e;
    @(negedge clk_i);
    sample_valid_i = v;
    sample_i       = s;
    resync_i       = rs;
    delta_ready_i  = rd;
    #1;
    exp_ready = (model_q.size() < 2);
    exp_valid = (model_q.size() != 0);
    checkOutput("sample_ready", {31'd0, sample_ready_o}, {31'd0, exp_ready});
    checkOutput("delta_valid", {31'd0, delta_valid_o}, {31'd0, exp_valid});
    if (exp_valid) begin
      checkOutput("head_delta", {24'd0, delta_o}, {24'd0, model_q[0].delta});
      checkOutput("head_first", {31'd0, first_o}, {31'd0, model_q[0].first});
    end
    obs_d = delta_o;
    obs_f = first_o;
    acc = v & exp_ready;
    pop = exp_valid & rd;
    @(posedge clk_i);
    if (pop) begin
      void'(model_q.pop_front());
      recon = obs_f ? obs_d : 8'(recon + obs_d);
      checkOutput("reconstruct", {24'd0, recon}, {24'd0, sample_q.pop_front()});
    end
    if (acc) begin
      d    = 8'(s - (rs ? 8'h00 : model_ref));
      skip = 1'b0;
`ifdef DELTA_EMITTER_ZERO_SKIP_EN
      skip = (d == 8'h00);
`endif
      if (!skip) begin
        e.first = model_first | rs;
        e.delta = d;
        model_q.push_back(e);
        sample_q.push_back(s);
        model_first = 1'b0;
      end else if (rs) begin
        model_first = 1'b1;
      end
      model_ref = s;
    end else if (rs) begin
      model_ref   = 8'h00;
      model_first = 1'b1;
    end
  endtask

  task automatic peekHead(input string tag, input logic [7:0] d, input logic f);
    #1;
    checkOutput({tag, "_valid"}, {31'd0, delta_valid_o}, 32'd1);
    checkOutput({tag, "_delta"}, {24'd0, delta_o}, {24'd0, d});
    checkOutput({tag, "_first"}, {31'd0, first_o}, {31'd0, f});
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] last_s;

    modelReset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("rst_ready", {31'd0, sample_ready_o}, 32'd1);
    checkOutput("rst_valid", {31'd0, delta_valid_o}, 32'd0);
    checkOutput("rst_delta", {24'd0, delta_o}, 32'd0);
    checkOutput("rst_first", {31'd0, first_o}, 32'd0);

    applyStimulus(1'b1, 8'h10, 1'b0, 1'b1); peekHead("d10", 8'h10, 1'b1);
    applyStimulus(1'b1, 8'h15, 1'b0, 1'b1); peekHead("d15", 8'h05, 1'b0);
    applyStimulus(1'b1, 8'h13, 1'b0, 1'b1); peekHead("d13", 8'hFE, 1'b0);
    applyStimulus(1'b1, 8'hFE, 1'b0, 1'b1); peekHead("dFE", 8'hEB, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b1); peekHead("wrap", 8'h04, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    #1;
    checkOutput("ready_after_two", {31'd0, sample_ready_o}, 32'd0);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b1, 8'h20, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h30, 1'b1, 1'b1); peekHead("resync_acc", 8'h30, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h40, 1'b0, 1'b1); peekHead("resync_idle", 8'h40, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef DELTA_EMITTER_ZERO_SKIP_EN
    applyStimulus(1'b1, 8'h07, 1'b1, 1'b1); peekHead("zs_07", 8'h07, 1'b1);
    applyStimulus(1'b1, 8'h07, 1'b0, 1'b1);
    #1;
    checkOutput("zs_skipped", {31'd0, delta_valid_o}, 32'd0);
    applyStimulus(1'b1, 8'h09, 1'b0, 1'b1); peekHead("zs_09", 8'h02, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b1); peekHead("zs_05", 8'h05, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
`endif

    last_s = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) s = last_s;
      else s = 8'($urandom_range(0, 255));
      applyStimulus(1'($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 2) != 0));
      if (sample_valid_i) last_s = s;
    end
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b1, 8'h50, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_valid", {31'd0, delta_valid_o}, 32'd0);
    checkOutput("async_rst_ready", {31'd0, sample_ready_o}, 32'd1);
    checkOutput("async_rst_first", {31'd0, first_o}, 32'd0);
    modelReset();
    sample_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1); peekHead("post_rst", 8'h33, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
